// File: rtl/xm23_mem_pkg.sv
// Shared types and constants for the XM23 memory bus-interface controller.
// Holds the controller state encoding, read/write codes and the wait-state limit.
package xm23_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int WAIT_STATES_MAX = 15;

  // Byte reads return the low RAM byte zero-extended; word reads join both halves.
  function automatic logic [15:0] pack_rdata(input logic       byte_acc,
                                             input logic [7:0] ub,
                                             input logic [7:0] lb);
    return byte_acc ? {8'h00, lb} : {ub, lb};
  endfunction

endpackage

// File: rtl/xm23_wait_timer.sv
// Loadable 4-bit down-counter used to time the WAIT state of xm23_mem_ctrl.
// zero_o flags an expired count; last_o flags the final counted cycle.
module xm23_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero_o,
  output logic       last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);
  assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/xm23_mem_ctrl.sv
// XM23 CPU-to-RAM bus-interface stage: one word/byte access per transaction, optional wait states.
// Build option MEM_ALIGN_FAULT_EN: odd word accesses raise fault instead of being forced even.
module xm23_mem_ctrl
  import xm23_mem_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic              byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_lb_addr,
  output logic [ADDR_W-1:0] mem_ub_addr,
  output logic [7:0]        mem_lb_wdata,
  output logic [7:0]        mem_ub_wdata,
  output logic              mem_lb_we,
  output logic              mem_ub_we,
  input  logic [7:0]        mem_lb_rdata,
  input  logic [7:0]        mem_ub_rdata
);

  localparam logic [3:0]        WS4      = 4'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] addr_acc;
  logic              align_fault;
  logic              tmr_load, tmr_dec, tmr_zero, tmr_last;

`ifdef MEM_ALIGN_FAULT_EN
  logic fault_q, fault_d;
  assign align_fault = ~byte_en & addr[0];
`else
  assign align_fault = 1'b0;
`endif

  xm23_wait_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (WS4),
    .dec      (tmr_dec),
    .zero_o   (tmr_zero),
    .last_o   (tmr_last)
  );

  always_comb begin
    addr_acc = addr;
`ifndef MEM_ALIGN_FAULT_EN
    // Word accesses always use the even byte of the pair.
    if (!byte_en) addr_acc[0] = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`ifdef MEM_ALIGN_FAULT_EN
    fault_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (align_fault) begin
            done_d  = 1'b1;
`ifdef MEM_ALIGN_FAULT_EN
            fault_d = 1'b1;
`endif
          end else begin
            rw_d    = rw;
            byte_d  = byte_en;
            addr_d  = addr_acc;
            wdata_d = wdata;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        tmr_load = 1'b1;
        state_d  = (WS4 == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_last || tmr_zero) state_d = RESP;
      end
      RESP: begin
        if (rw_q == RW_READ) begin
          rdata_d = pack_rdata(byte_q, mem_ub_rdata, mem_lb_rdata);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= RW_READ;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

`ifdef MEM_ALIGN_FAULT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // RAM side is driven only while a transaction is in flight, so reset clears it at once.
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign rdata        = rdata_q;
  assign mem_lb_addr  = busy ? addr_q : '0;
  assign mem_ub_addr  = busy ? (addr_q + ADDR_ONE) : '0;
  assign mem_lb_wdata = (busy && (rw_q == RW_WRITE)) ? wdata_q[7:0]  : 8'h00;
  assign mem_ub_wdata = (busy && (rw_q == RW_WRITE)) ? wdata_q[15:8] : 8'h00;
  assign mem_lb_we    = (state_q == ACCESS) && (rw_q == RW_WRITE);
  assign mem_ub_we    = (state_q == ACCESS) && (rw_q == RW_WRITE) && !byte_q;

endmodule

// File: tb/tb_xm23_mem_ctrl.sv
// Scoreboard bench for xm23_mem_ctrl: two instances (0 and 3 wait states), each with its own RAM.
// Honours MEM_ALIGN_FAULT_EN when building the expected responses.
module tb_xm23_mem_ctrl;

  typedef struct {
    int          acc;
    bit          wr;
    bit          byt;
    bit          flt;
    logic [15:0] la;
    logic [15:0] ua;
    logic [15:0] wd;
    logic [15:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_i [2];
  logic        rw_i  [2];
  logic        be_i  [2];
  logic [15:0] addr_i[2];
  logic [15:0] wd_i  [2];
  logic        busy_o[2], done_o[2], fault_o[2];
  logic [15:0] rdata_o[2], lba[2], uba[2];
  logic [7:0]  lbw[2], ubw[2], lbr[2], ubr[2];
  logic        lbwe[2], ubwe[2];

  xm23_mem_ctrl #(.WAIT_STATES(0), .ADDR_W(16)) dut0 (
    .clk(clk), .rst(rst), .req(req_i[0]), .rw(rw_i[0]), .byte_en(be_i[0]),
    .addr(addr_i[0]), .wdata(wd_i[0]), .busy(busy_o[0]), .done(done_o[0]),
    .rdata(rdata_o[0]), .fault(fault_o[0]), .mem_lb_addr(lba[0]), .mem_ub_addr(uba[0]),
    .mem_lb_wdata(lbw[0]), .mem_ub_wdata(ubw[0]), .mem_lb_we(lbwe[0]), .mem_ub_we(ubwe[0]),
    .mem_lb_rdata(lbr[0]), .mem_ub_rdata(ubr[0]));

  xm23_mem_ctrl #(.WAIT_STATES(3), .ADDR_W(16)) dut1 (
    .clk(clk), .rst(rst), .req(req_i[1]), .rw(rw_i[1]), .byte_en(be_i[1]),
    .addr(addr_i[1]), .wdata(wd_i[1]), .busy(busy_o[1]), .done(done_o[1]),
    .rdata(rdata_o[1]), .fault(fault_o[1]), .mem_lb_addr(lba[1]), .mem_ub_addr(uba[1]),
    .mem_lb_wdata(lbw[1]), .mem_ub_wdata(ubw[1]), .mem_lb_we(lbwe[1]), .mem_ub_we(ubwe[1]),
    .mem_lb_rdata(lbr[1]), .mem_ub_rdata(ubr[1]));

  function automatic int wsof(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic [7:0] pat(input int i, input int a);
    return 8'((a * 37) ^ (a >> 5) ^ (i * 91));
  endfunction

  // Byte-wide synchronous RAM per instance (read-before-write).
  logic [7:0] ram [2][65536];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preload) begin
        for (int a = 0; a < 65536; a++) ram[i][a] <= pat(i, a);
      end else begin
        if (lbwe[i]) ram[i][lba[i]] <= lbw[i];
        if (ubwe[i]) ram[i][uba[i]] <= ubw[i];
      end
      lbr[i] <= ram[i][lba[i]];
      ubr[i] <= ram[i][uba[i]];
    end
  end

  // Reference model: memory image, held rdata and the first cycle each instance is idle again.
  logic [7:0]  refm [2][65536];
  logic [15:0] mrd    [2];
  int          free_at[2];
  exp_t        sb     [2][$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input int i, input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s at cycle %0d: got %h, required %h", i, nm, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input int i);
    chk(i, "rst_busy",  16'(busy_o[i]), 16'h0);
    chk(i, "rst_done",  16'(done_o[i]), 16'h0);
    chk(i, "rst_fault", 16'(fault_o[i]), 16'h0);
    chk(i, "rst_rdata", rdata_o[i], 16'h0);
    chk(i, "rst_lbaddr", lba[i], 16'h0);
    chk(i, "rst_ubaddr", uba[i], 16'h0);
    chk(i, "rst_wdata", {ubw[i], lbw[i]}, 16'h0);
    chk(i, "rst_we", {14'h0, ubwe[i], lbwe[i]}, 16'h0);
  endtask

  function automatic int done_period(input exp_t e, input int w);
    return e.flt ? e.acc : e.acc + 2 + w;
  endfunction

  // Monitor: derive this cycle's expected outputs from every outstanding transaction.
  task automatic check_cycle(input int i);
    int   w;
    bit   eb, ha, hd;
    logic elw, euw, ef;
    exp_t e, ea, edn;
    w = wsof(i);
    eb = 0; ha = 0; hd = 0; elw = 0; euw = 0; ef = 0;
    ea = '{default: 0};
    edn = '{default: 0};
    for (int k = 0; k < sb[i].size(); k++) begin
      e = sb[i][k];
      if (!e.flt && cyc >= e.acc && cyc <= e.acc + 1 + w) eb = 1;
      if (!e.flt && cyc == e.acc) begin
        ha = 1; ea = e; elw = e.wr; euw = e.wr && !e.byt;
      end
      if (cyc == done_period(e, w)) begin
        hd = 1; edn = e; ef = e.flt;
      end
    end
    chk(i, "busy",  16'(busy_o[i]), 16'(eb));
    chk(i, "lb_we", 16'(lbwe[i]), 16'(elw));
    chk(i, "ub_we", 16'(ubwe[i]), 16'(euw));
    chk(i, "done",  16'(done_o[i]), 16'(hd));
    chk(i, "fault", 16'(fault_o[i]), 16'(ef));
    if (ha) begin
      chk(i, "lb_addr", lba[i], ea.la);
      chk(i, "ub_addr", uba[i], ea.ua);
      if (ea.wr) chk(i, "lb_wdata", 16'(lbw[i]), 16'(ea.wd[7:0]));
      if (ea.wr && !ea.byt) chk(i, "ub_wdata", 16'(ubw[i]), 16'(ea.wd[15:8]));
    end
    if (hd) chk(i, "rdata", rdata_o[i], edn.rd);
    while (sb[i].size() > 0 && done_period(sb[i][0], w) <= cyc) void'(sb[i].pop_front());
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) check_cycle(i);
  end

  // Issue one request on instance i once it is idle; returns 1 time unit into the ACCESS cycle.
  task automatic issue(input int i, input bit wr, input bit byt, input logic [15:0] a,
                       input logic [15:0] wd, input bit commit);
    exp_t        e;
    logic [15:0] eff;
    bit          flt;
    eff = a;
    flt = 0;
`ifdef MEM_ALIGN_FAULT_EN
    if (!byt && a[0]) flt = 1;
`else
    if (!byt) eff[0] = 1'b0;
`endif
    e.wr = wr; e.byt = byt; e.flt = flt; e.wd = wd;
    e.la = eff;
    e.ua = eff + 16'd1;
    e.rd = mrd[i];
    if (!flt && !wr) e.rd = byt ? {8'h00, refm[i][e.la]} : {refm[i][e.ua], refm[i][e.la]};
    while (cyc < free_at[i]) begin
      @(posedge clk);
      #1;
    end
    req_i[i] = 1'b1; rw_i[i] = wr; be_i[i] = byt; addr_i[i] = a; wd_i[i] = wd;
    e.acc = cyc + 1;
    if (commit) begin
      if (!flt && wr) begin
        refm[i][e.la] = wd[7:0];
        if (!byt) refm[i][e.ua] = wd[15:8];
      end
      mrd[i] = e.rd;
      sb[i].push_back(e);
      free_at[i] = flt ? e.acc : e.acc + 2 + wsof(i);
    end
    @(posedge clk);
    #1;
    req_i[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    preload = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_i[i] = 1'b0; rw_i[i] = 1'b0; be_i[i] = 1'b0; addr_i[i] = 16'h0; wd_i[i] = 16'h0;
      mrd[i] = 16'h0; free_at[i] = 0;
      for (int a = 0; a < 65536; a++) refm[i][a] = pat(i, a);
    end
    #2;
    chk_zero(0);
    chk_zero(1);
    @(posedge clk); #1 preload = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Directed: word write/read, byte read, byte write then word read, wrap cases.
    issue(0, 1, 0, 16'h0100, 16'hBEEF, 1);
    issue(0, 0, 0, 16'h0100, 16'h0000, 1);
    issue(0, 0, 1, 16'h0101, 16'h0000, 1);
    issue(0, 1, 1, 16'h0200, 16'h3355, 1);
    issue(0, 0, 0, 16'h0200, 16'h0000, 1);
    issue(0, 0, 0, 16'hFFFF, 16'h0000, 1);
    issue(0, 0, 1, 16'hFFFF, 16'h0000, 1);
    issue(0, 1, 1, 16'hFFFF, 16'h00A7, 1);
    issue(0, 0, 0, 16'hFFFE, 16'h0000, 1);

    // Wait states plus a request held high mid-transaction that must be ignored.
    issue(1, 0, 0, 16'h0010, 16'h0000, 1);
    req_i[1] = 1'b1; rw_i[1] = 1'b1; be_i[1] = 1'b0; addr_i[1] = 16'h0300; wd_i[1] = 16'hDEAD;
    repeat (4) @(posedge clk);
    #1 req_i[1] = 1'b0;
    issue(1, 1, 0, 16'h0010, 16'h1234, 1);
    issue(1, 0, 1, 16'h0011, 16'h0000, 1);
    issue(1, 0, 0, 16'h0300, 16'h0000, 1);

    // Randomized traffic over a small window so reads hit earlier writes.
    for (int n = 0; n < 300; n++) begin
      int          i;
      bit          wr, byt;
      logic [15:0] a;
      i   = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                        : 16'(16'h0100 + $urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(i, wr, byt, a, 16'($urandom), 1);
    end

    // Reset during the ACCESS cycle of a word write on instance 0.
    issue(0, 1, 0, 16'h0120, 16'hC0DE, 0);
    chk(0, "we_before_rst", {14'h0, ubwe[0], lbwe[0]}, 16'h0003);
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb[i].delete();
      mrd[i] = 16'h0;
      free_at[i] = 0;
    end
    #1;
    chk_zero(0);
    chk_zero(1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(0, 0, 0, 16'h0120, 16'h0000, 1);
    issue(1, 0, 0, 16'h0010, 16'h0000, 1);

    repeat (12) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
